decode_stage: RTL and testbench
===============================

# decode_stage

Registered, handshaked instruction decode stage for the 16-bit core. Accepts a raw instruction word from fetch over valid/ready, decodes the 4-bit opcode into the datapath control bundle, sign-extends the selected immediate to XLEN, and presents the result to execute one cycle later. A 2-entry skid buffer decouples backpressure, so `in_ready` is registered. The block also flags illegal encodings and counts them.

## Interface
- `XLEN`, 16, width of the sign-extended immediate (≥ 9).
- `CNT_W`, 8, width of the illegal-instruction counter.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous pipeline kill.
- `in_valid` in 1: instruction word valid.
- `in_ready` out 1: stage can accept; registered.
- `in_instr` in 16: raw instruction.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: execute accepts bundle.
- `reg_write`, `reg_dst`, `alu_src2`, `mem_write`, `mem_to_reg`, `reg_src`, `is_branch`, `illegal` out 1 each: control bits.
- `alu_op` out 4: ALU operation.
- `imm` out XLEN: sign-extended immediate.
- `rd`, `rs` out 3 each: `in_instr[11:9]`, `in_instr[8:6]`.
- `illegal_count` out CNT_W: saturating count of accepted illegal instructions.

## Operation
- Fields: opcode = [15:12], imm7 = [6:0], nzimm6 = [5:0], off9 = [8:0].
- Decode. Bits are listed as reg_write/reg_dst/alu_src2/mem_write/mem_to_reg/reg_src, then alu_op and immediate:
  - 0000 load: 1/1/1/0/1/0, op 0000, imm7.
  - 0001 store: 0/0/1/1/0/0, op 0000, imm7.
  - 0010: 1/1/0/0/0/1, op 0000, imm 0.
  - 0011: 1/1/1/0/0/1, op 0000, nzimm6.
  - 0100: 1/1/0/0/0/1, op 0010, imm 0.
  - 0101: 1/1/1/0/0/1, op 0010, imm7.
  - 0110: 1/1/0/0/0/1, op 0011, imm 0.
  - 0111: 1/1/0/0/0/1, op 1000, imm 0.
  - 1000: 1/1/1/0/0/1, op 0100, nzimm6.
  - 1001: 1/1/1/0/0/1, op 0101, nzimm6.
  - 1010: 0/0/1/0/0/0, op 0110, off9, is_branch = 1.
  - 1011: 0/0/1/0/0/0, op 0111, off9, is_branch = 1.
- The selected immediate is sign-extended from its MSB to XLEN. `is_branch` = 0 for every opcode except 1010/1011.
- Illegal encodings are opcode 1100–1111, and 0011/1000/1001 with nzimm6 = 0.
  - Illegal instructions drive all control bits, `alu_op` and `imm` to 0, with `illegal` = 1. They still pass through the pipe as a valid bundle so execute can trap.
- Buffer: a main output register plus one skid register.
  - Accept happens when `in_valid && in_ready && !flush`.
  - If the output register is empty or drained this cycle, the decoded bundle loads into the output register; otherwise it loads into the skid register.
  - When the output register drains and the skid register is full, the skid register moves to output.
  - `in_ready` = skid register empty.
- `flush`: at the next edge both entries are invalidated. An instruction offered during the flush cycle is dropped and not counted. `illegal_count` is unaffected by flush.
- `illegal_count` increments by 1 on each accepted illegal instruction and saturates at 2^CNT_W − 1.

## Timing
- Reset (async assert, sync release): `out_valid` = 0, `in_ready` = 1, `illegal_count` = 0, all bundle outputs 0, skid empty.
- Latency: instruction accepted at edge N appears with `out_valid` = 1 after edge N (visible in cycle N+1).
- Throughput: 1 instruction/cycle while `out_ready` = 1.
- Outputs are stable while `out_valid && !out_ready`. There is no loss and no duplication under any ready pattern.
- `in_ready` falls the cycle after the skid register fills. It rises the cycle after the skid register drains.
- Simultaneous accept and drain with skid empty: the new bundle replaces the output register. Occupancy is unchanged.
- Simultaneous flush and `out_ready`: the flush wins; the bundle in the output register counts as consumed by execute.
- Reset asserted mid-transfer: all state clears immediately. Partially held bundles are discarded.

## Test plan
- Reset: hold `rst_n` = 0 with random inputs → `out_valid` = 0, `in_ready` = 1, `illegal_count` = 0. Release, then stream all 12 legal opcodes with `out_ready` = 1 → each bundle matches the decode list one cycle later.
- Sign extension: instr 0x0040 (imm7 = 0x40) → imm = 0xFFC0. Instr 0xA100 (off9 = 0x100) → imm = 0xFF00, is_branch = 1. Instr 0x303F → imm = 0xFFFF.
- Illegal: instr 0xC000, then 0x3000 (nzimm = 0) → both emerge with `illegal` = 1, all controls 0, `illegal_count` = 2. Force 300 illegal instructions with CNT_W = 8 → count saturates at 255.
- Backpressure: stream 6 instructions, `out_ready` = 0 for 3 cycles → `in_ready` drops after 2 accepted. On release, all 6 emerge in order with none lost or duplicated.
- Flush: 2 entries held, pulse `flush` with `in_valid` = 1 → next cycle `out_valid` = 0, `in_ready` = 1, the offered instruction is not seen and the count is unchanged.
- Async reset mid-stream: assert `rst_n` low between edges → outputs clear before the next edge.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage for the 16-bit core.
// Turns a raw instruction word into the execute control bundle and
// sign-extends the selected immediate. The result is held in an output
// register backed by one skid register, so in_ready comes from a flop.
// Accepted illegal encodings are counted with a saturating counter.
module decode_stage #(
    parameter int XLEN  = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src2,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_src,
    output logic             is_branch,
    output logic             illegal,
    output logic [3:0]       alu_op,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       rd,
    output logic [2:0]       rs,
    output logic [CNT_W-1:0] illegal_count
);

    typedef struct packed {
        logic            reg_write;
        logic            reg_dst;
        logic            alu_src2;
        logic            mem_write;
        logic            mem_to_reg;
        logic            reg_src;
        logic            is_branch;
        logic            illegal;
        logic [3:0]      alu_op;
        logic [XLEN-1:0] imm;
        logic [2:0]      rd;
        logic [2:0]      rs;
    } bundle_t;

    bundle_t          dec;
    bundle_t          out_b_q, out_b_d;
    bundle_t          skid_b_q, skid_b_d;
    logic             out_v_q, out_v_d;
    logic             skid_v_q, skid_v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             drain;

    logic [XLEN-1:0]  imm7_x;
    logic [XLEN-1:0]  nz6_x;
    logic [XLEN-1:0]  off9_x;
    logic             nz_ok;

    assign imm7_x = {{(XLEN-7){in_instr[6]}}, in_instr[6:0]};
    assign nz6_x  = {{(XLEN-6){in_instr[5]}}, in_instr[5:0]};
    assign off9_x = {{(XLEN-9){in_instr[8]}}, in_instr[8:0]};
    assign nz_ok  = |in_instr[5:0];

    // Combinational decode of the incoming word; illegal words keep every
    // control, alu_op and imm at zero and only raise the illegal flag.
    always_comb begin
        dec    = '0;
        dec.rd = in_instr[11:9];
        dec.rs = in_instr[8:6];
        unique case (in_instr[15:12])
            4'h0: begin
                {dec.reg_write, dec.reg_dst, dec.alu_src2, dec.mem_write, dec.mem_to_reg, dec.reg_src} = 6'b111010;
                dec.imm = imm7_x;
            end
            4'h1: begin
                {dec.reg_write, dec.reg_dst, dec.alu_src2, dec.mem_write, dec.mem_to_reg, dec.reg_src} = 6'b001100;
                dec.imm = imm7_x;
            end
            4'h2: begin
                {dec.reg_write, dec.reg_dst, dec.alu_src2, dec.mem_write, dec.mem_to_reg, dec.reg_src} = 6'b110001;
            end
            4'h3: begin
                if (nz_ok) begin
                    {dec.reg_write, dec.reg_dst, dec.alu_src2, dec.mem_write, dec.mem_to_reg, dec.reg_src} = 6'b111001;
                    dec.imm = nz6_x;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            4'h4: begin
                {dec.reg_write, dec.reg_dst, dec.alu_src2, dec.mem_write, dec.mem_to_reg, dec.reg_src} = 6'b110001;
                dec.alu_op = 4'b0010;
            end
            4'h5: begin
                {dec.reg_write, dec.reg_dst, dec.alu_src2, dec.mem_write, dec.mem_to_reg, dec.reg_src} = 6'b111001;
                dec.alu_op = 4'b0010;
                dec.imm    = imm7_x;
            end
            4'h6: begin
                {dec.reg_write, dec.reg_dst, dec.alu_src2, dec.mem_write, dec.mem_to_reg, dec.reg_src} = 6'b110001;
                dec.alu_op = 4'b0011;
            end
            4'h7: begin
                {dec.reg_write, dec.reg_dst, dec.alu_src2, dec.mem_write, dec.mem_to_reg, dec.reg_src} = 6'b110001;
                dec.alu_op = 4'b1000;
            end
            4'h8, 4'h9: begin
                if (nz_ok) begin
                    {dec.reg_write, dec.reg_dst, dec.alu_src2, dec.mem_write, dec.mem_to_reg, dec.reg_src} = 6'b111001;
                    dec.alu_op = in_instr[12] ? 4'b0101 : 4'b0100;
                    dec.imm    = nz6_x;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            4'hA, 4'hB: begin
                {dec.reg_write, dec.reg_dst, dec.alu_src2, dec.mem_write, dec.mem_to_reg, dec.reg_src} = 6'b001000;
                dec.alu_op    = in_instr[12] ? 4'b0111 : 4'b0110;
                dec.imm       = off9_x;
                dec.is_branch = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign accept = in_valid && !skid_v_q && !flush;
    assign drain  = out_v_q && out_ready;

    // Next state of the output/skid pair and the illegal counter. The skid
    // entry always takes priority into the output register so order holds.
    always_comb begin
        out_v_d  = out_v_q;
        skid_v_d = skid_v_q;
        out_b_d  = out_b_q;
        skid_b_d = skid_b_q;
        cnt_d    = cnt_q;
        if (flush) begin
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
        end else if (!out_v_q || drain) begin
            if (skid_v_q) begin
                out_b_d  = skid_b_q;
                out_v_d  = 1'b1;
                skid_v_d = 1'b0;
            end else if (accept) begin
                out_b_d = dec;
                out_v_d = 1'b1;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (accept) begin
            skid_b_d = dec;
            skid_v_d = 1'b1;
        end
        if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset clears both entries and the counter at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
            out_b_q  <= '0;
            skid_b_q <= '0;
            cnt_q    <= '0;
        end else begin
            out_v_q  <= out_v_d;
            skid_v_q <= skid_v_d;
            out_b_q  <= out_b_d;
            skid_b_q <= skid_b_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready      = !skid_v_q;
    assign out_valid     = out_v_q;
    assign reg_write     = out_b_q.reg_write;
    assign reg_dst       = out_b_q.reg_dst;
    assign alu_src2      = out_b_q.alu_src2;
    assign mem_write     = out_b_q.mem_write;
    assign mem_to_reg    = out_b_q.mem_to_reg;
    assign reg_src       = out_b_q.reg_src;
    assign is_branch     = out_b_q.is_branch;
    assign illegal       = out_b_q.illegal;
    assign alu_op        = out_b_q.alu_op;
    assign imm           = out_b_q.imm;
    assign rd            = out_b_q.rd;
    assign rs            = out_b_q.rs;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a queue-based transaction model predicts every
// output each cycle; directed phases pin sign extension, illegal handling,
// backpressure, flush, counter saturation and asynchronous reset.
module tb_decode_stage;

    localparam int XLEN  = 16;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic             reg_write, reg_dst, alu_src2, mem_write, mem_to_reg, reg_src, is_branch, illegal;
    logic [3:0]       alu_op;
    logic [XLEN-1:0]  imm;
    logic [2:0]       rd, rs;
    logic [CNT_W-1:0] illegal_count;

    decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src2(alu_src2),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_src(reg_src),
        .is_branch(is_branch), .illegal(illegal), .alu_op(alu_op),
        .imm(imm), .rd(rd), .rs(rs), .illegal_count(illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  ctl;
        logic        br;
        logic        ill;
        logic [3:0]  op;
        logic [15:0] imm;
        logic [2:0]  rd;
        logic [2:0]  rs;
    } bun_t;

    // Decode table from the instruction set listing, indexed by opcode.
    // SEL: 0 = no immediate, 1 = imm7, 2 = nzimm6, 3 = off9.
    localparam logic [5:0] CTL_TAB [12] = '{6'b111010, 6'b001100, 6'b110001, 6'b111001,
                                            6'b110001, 6'b111001, 6'b110001, 6'b110001,
                                            6'b111001, 6'b111001, 6'b001000, 6'b001000};
    localparam logic [3:0] OP_TAB  [12] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd2,
                                            4'd3, 4'd8, 4'd4, 4'd5, 4'd6, 4'd7};
    localparam int         SEL_TAB [12] = '{1, 1, 0, 2, 0, 1, 0, 0, 2, 2, 3, 3};

    int n_tests = 0;
    int n_fail  = 0;
    bun_t mq[$];
    int   mcnt;
    bit   chk_en = 1'b0;
    bun_t dut_b;

    assign dut_b = {reg_write, reg_dst, alu_src2, mem_write, mem_to_reg, reg_src,
                    is_branch, illegal, alu_op, imm, rd, rs};

    function automatic bun_t model_decode(input logic [15:0] w);
        bun_t b;
        int   opc;
        int   sel;
        int   v;
        b    = '0;
        b.rd = w[11:9];
        b.rs = w[8:6];
        opc  = int'(w[15:12]);
        if (opc >= 12) begin
            b.ill = 1'b1;
            return b;
        end
        sel = SEL_TAB[opc];
        if (sel == 2 && w[5:0] == 6'd0) begin
            b.ill = 1'b1;
            return b;
        end
        case (sel)
            0:       v = 0;
            1:       v = int'(w[6:0]) - (w[6] ? 128 : 0);
            2:       v = int'(w[5:0]) - (w[5] ? 64 : 0);
            default: v = int'(w[8:0]) - (w[8] ? 512 : 0);
        endcase
        b.ctl = CTL_TAB[opc];
        b.op  = OP_TAB[opc];
        b.imm = 16'(v);
        b.br  = (opc == 10 || opc == 11);
        return b;
    endfunction

    function automatic logic [15:0] rand_legal();
        logic [15:0] w;
        w = 16'($urandom);
        w[15:12] = 4'($urandom_range(0, 11));
        if ((w[15:12] == 4'd3 || w[15:12] == 4'd8 || w[15:12] == 4'd9) && w[5:0] == 6'd0) w[0] = 1'b1;
        return w;
    endfunction

    function automatic logic [15:0] rand_illegal();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 1) == 0) begin
            w[15:12] = 4'($urandom_range(12, 15));
        end else begin
            case ($urandom_range(0, 2))
                0:       w[15:12] = 4'd3;
                1:       w[15:12] = 4'd8;
                default: w[15:12] = 4'd9;
            endcase
            w[5:0] = 6'd0;
        end
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: the stage is a FIFO of depth two whose head is the
    // output register; in_ready means fewer than two entries are held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mcnt <= 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            automatic int   sz = mq.size();
            automatic bun_t nb = model_decode(in_instr);
            if (sz > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && sz < 2) begin
                mq.push_back(nb);
                if (nb.ill && mcnt < 255) mcnt <= mcnt + 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
            chk("illegal_count", 64'(illegal_count), 64'(mcnt));
            if (out_valid && mq.size() > 0) chk("bundle", 64'(dut_b), 64'(mq[0]));
        end
    end

    task automatic send(input logic [15:0] w);
        int budget;
        bit acc;
        budget   = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_instr = w;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk);
            #1;
            budget++;
            if (!acc && budget > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
                acc = 1'b1;
            end
        end
    endtask

    logic [15:0] w;
    bun_t        pb;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'h0;
        out_ready = 1'b0;

        // Pin the model itself against hand-computed values.
        pb = model_decode(16'h0040); chk("model_imm7", 64'(pb.imm), 64'hFFC0);
        pb = model_decode(16'hA100); chk("model_off9", 64'({pb.br, pb.imm}), 64'h1FF00);
        pb = model_decode(16'h303F); chk("model_nz6", 64'(pb.imm), 64'hFFFF);
        pb = model_decode(16'h3000); chk("model_nz0", 64'({pb.ill, pb.ctl}), 64'h40);
        pb = model_decode(16'h0E85); chk("model_load", 64'(pb), 64'({6'b111010, 1'b0, 1'b0, 4'd0, 16'h0005, 3'd7, 3'd2}));
        pb = model_decode(16'hB1FF); chk("model_branch", 64'({pb.op, pb.imm}), 64'h7FFFF);

        chk_en = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom);
            flush     = 1'($urandom);
            out_ready = 1'($urandom);
            in_instr  = 16'($urandom);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'h1);
        chk("reset_count", 64'(illegal_count), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All twelve legal opcodes back to back.
        for (int op = 0; op < 12; op++) begin
            w = 16'($urandom);
            w[15:12] = 4'(op);
            if (w[5:0] == 6'd0) w[0] = 1'b1;
            send(w);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Directed sign extension and illegal encodings.
        send(16'h0040); in_valid = 1'b0;
        chk("imm_0040", 64'(imm), 64'hFFC0);
        send(16'hA100); in_valid = 1'b0;
        chk("imm_A100", 64'({is_branch, imm}), 64'h1FF00);
        send(16'h303F); in_valid = 1'b0;
        chk("imm_303F", 64'(imm), 64'hFFFF);
        send(16'hC000); in_valid = 1'b0;
        chk("ill_C000", 64'({illegal, reg_write, alu_src2, alu_op, imm}), 64'h400000);
        send(16'h3000); in_valid = 1'b0;
        chk("ill_3000", 64'({illegal, reg_write, alu_src2, reg_src, alu_op, imm}), 64'h800000);
        chk("count_two", 64'(illegal_count), 64'd2);
        @(posedge clk); #1;

        // Backpressure: two entries fill, third is refused until drain.
        out_ready = 1'b0;
        send(rand_legal());
        send(rand_legal());
        chk("bp_in_ready_low", 64'(in_ready), 64'h0);
        in_instr = rand_legal();
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(in_instr);
        repeat (3) send(rand_legal());
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Flush with two held entries and an illegal word on offer.
        out_ready = 1'b0;
        send(rand_legal());
        send(rand_legal());
        in_instr = 16'hC000;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        chk("flush_in_ready", 64'(in_ready), 64'h1);
        chk("flush_count", 64'(illegal_count), 64'd2);
        out_ready = 1'b1;

        // Random traffic against the model.
        repeat (400) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Saturation of the illegal counter.
        for (int i = 0; i < 300; i++) send(rand_illegal());
        in_valid = 1'b0;
        chk("count_saturated", 64'(illegal_count), 64'd255);
        @(posedge clk); #1;

        // Asynchronous reset between edges while data is held.
        out_ready = 1'b0;
        send(rand_legal());
        send(rand_legal());
        in_valid = 1'b1;
        in_instr = rand_legal();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'h0);
        chk("arst_in_ready", 64'(in_ready), 64'h1);
        chk("arst_count", 64'(illegal_count), 64'h0);
        chk("arst_imm", 64'(imm), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
